// File: rtl/dma_rx_pkt_buffer.sv
// dma_rx_pkt_buffer: store-and-forward packet buffer for the card-to-host receive path.
// A packet is released downstream only after its last beat has been stored. The first output
// beat carries the packet byte length in tuser[15:0]. A packet that does not fit in the data
// RAM is dropped whole, and each such drop increments drop_count.
//
// Ports:
//   axi_aclk, axi_resetn  - clock, asynchronous active-low reset
//   s_axis_*              - 64-bit AXI4-Stream input (tuser sampled on first beat)
//   m_axis_*              - AXI4-Stream output, length stamped into tuser of first beat
//   drop_count            - packets dropped since reset (wraps)
module dma_rx_pkt_buffer #(
    parameter int unsigned C_AXIS_DATA_WIDTH  = 64,
    parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_DEPTH_LOG2       = 8,
    parameter int unsigned C_META_DEPTH_LOG2  = 4
) (
    input  logic                            axi_aclk,
    input  logic                            axi_resetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [31:0]                     drop_count
);
    localparam int unsigned StrbW     = C_AXIS_DATA_WIDTH / 8;
    localparam int unsigned WordW     = C_AXIS_DATA_WIDTH + StrbW + 1;
    localparam int unsigned Depth     = 2 ** C_DEPTH_LOG2;
    localparam int unsigned MetaDepth = 2 ** C_META_DEPTH_LOG2;
    localparam int unsigned PtrW      = C_DEPTH_LOG2 + 1;
    localparam int unsigned MPtrW     = C_META_DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {W_FIRST, W_BODY, W_DROP} wr_state_e;
    typedef enum logic {R_IDLE, R_SEND} rd_state_e;

    function automatic logic [15:0] popcount(input logic [StrbW-1:0] v);
        logic [15:0] c;
        c = '0;
        for (int i = 0; i < int'(StrbW); i++) begin
            c = c + 16'(v[i]);
        end
        return c;
    endfunction

    // Word layout: {tdata, tstrb, tlast}
    logic [WordW-1:0]              data_mem [Depth];
    logic [C_AXIS_TUSER_WIDTH-1:0] meta_mem [MetaDepth];

    logic [PtrW-1:0]               wr_ptr, wr_commit, rd_ptr;
    logic [MPtrW-1:0]              meta_wr_ptr, meta_rd_ptr;
    wr_state_e                     wr_state;
    rd_state_e                     rd_state;
    logic [15:0]                   len_acc;
    logic [C_AXIS_TUSER_WIDTH-1:0] tuser_hold;

    logic [PtrW-1:0]               used;
    logic [MPtrW-1:0]              meta_used;
    logic                          meta_full, meta_empty, buf_full;
    logic                          s_accept, data_we, overflow, meta_push, meta_pop, m_hs;
    logic [15:0]                   pkt_len;
    logic [C_AXIS_TUSER_WIDTH-1:0] meta_entry;
    logic [WordW-1:0]              rd_word;

    always_comb begin
        used          = wr_ptr - rd_ptr;
        meta_used     = meta_wr_ptr - meta_rd_ptr;
        meta_full     = (meta_used == MPtrW'(MetaDepth));
        meta_empty    = (meta_wr_ptr == meta_rd_ptr);
        // Full check uses the registered rd_ptr: a read this cycle frees space next cycle.
        buf_full      = (used == PtrW'(Depth));
        s_axis_tready = ~meta_full;
        s_accept      = s_axis_tvalid & s_axis_tready;
        overflow      = s_accept & (wr_state != W_DROP) & buf_full;
        data_we       = s_accept & (wr_state != W_DROP) & ~buf_full;
        meta_push     = data_we & s_axis_tlast;

        pkt_len    = (wr_state == W_FIRST) ? popcount(s_axis_tstrb)
                                           : len_acc + popcount(s_axis_tstrb);
        // Single-beat packets never reach the tuser_hold register, so use the live value.
        meta_entry = (wr_state == W_FIRST) ? s_axis_tuser : tuser_hold;
        meta_entry[15:0] = pkt_len;
    end

    always_comb begin
        rd_word       = data_mem[rd_ptr[C_DEPTH_LOG2-1:0]];
        m_axis_tvalid = (rd_state == R_SEND) | ~meta_empty;
        m_hs          = m_axis_tvalid & m_axis_tready;
        meta_pop      = m_hs & (rd_state == R_IDLE);
        m_axis_tdata  = m_axis_tvalid ? rd_word[WordW-1:StrbW+1] : '0;
        m_axis_tstrb  = m_axis_tvalid ? rd_word[StrbW:1] : '0;
        m_axis_tlast  = m_axis_tvalid & rd_word[0];
        m_axis_tuser  = (rd_state == R_IDLE && !meta_empty)
                      ? meta_mem[meta_rd_ptr[C_META_DEPTH_LOG2-1:0]] : '0;
    end

    // Storage arrays carry no reset; validity is tracked by the pointers.
    always_ff @(posedge axi_aclk) begin
        if (data_we) begin
            data_mem[wr_ptr[C_DEPTH_LOG2-1:0]] <= {s_axis_tdata, s_axis_tstrb, s_axis_tlast};
        end
        if (meta_push) begin
            meta_mem[meta_wr_ptr[C_META_DEPTH_LOG2-1:0]] <= meta_entry;
        end
    end

    // Write side
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wr_state    <= W_FIRST;
            wr_ptr      <= '0;
            wr_commit   <= '0;
            len_acc     <= '0;
            tuser_hold  <= '0;
            meta_wr_ptr <= '0;
            drop_count  <= '0;
        end else begin
            if (s_accept && wr_state == W_FIRST) begin
                tuser_hold <= s_axis_tuser;
            end
            if (data_we) begin
                wr_ptr  <= wr_ptr + PtrW'(1);
                len_acc <= pkt_len;
                if (s_axis_tlast) begin
                    wr_commit   <= wr_ptr + PtrW'(1);
                    meta_wr_ptr <= meta_wr_ptr + MPtrW'(1);
                    wr_state    <= W_FIRST;
                end else begin
                    wr_state <= W_BODY;
                end
            end else if (overflow) begin
                // Roll back everything written for this packet.
                wr_ptr     <= wr_commit;
                drop_count <= drop_count + 32'd1;
                wr_state   <= s_axis_tlast ? W_FIRST : W_DROP;
            end else if (s_accept && wr_state == W_DROP && s_axis_tlast) begin
                wr_state <= W_FIRST;
            end
        end
    end

    // Read side
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            rd_state    <= R_IDLE;
            rd_ptr      <= '0;
            meta_rd_ptr <= '0;
        end else begin
            if (m_hs) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            if (meta_pop) begin
                meta_rd_ptr <= meta_rd_ptr + MPtrW'(1);
            end
            unique case (rd_state)
                R_IDLE: if (m_hs && !m_axis_tlast) rd_state <= R_SEND;
                R_SEND: if (m_hs && m_axis_tlast) rd_state <= R_IDLE;
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dma_rx_pkt_buffer.md
# dma_rx_pkt_buffer

Store-and-forward packet buffer on the card-to-host receive path, in the 250 MHz domain directly downstream of the width/clock converter stage. It accepts a 64-bit AXI4-Stream, holds each packet until its last beat arrives, and stamps the packet byte length into `tuser` of the first output beat. The DMA engine therefore only sees complete packets with a known length up front. Packets that cannot fit are dropped whole and counted.

## Interface
Parameters:
- `C_AXIS_DATA_WIDTH`, default 64: data width, same on both sides.
- `C_AXIS_TUSER_WIDTH`, default 128: `tuser` width.
- `C_DEPTH_LOG2`, default 8: data RAM depth is 2^C_DEPTH_LOG2 beats.
- `C_META_DEPTH_LOG2`, default 4: packet metadata FIFO depth is 2^C_META_DEPTH_LOG2 entries.

Ports:
- `axi_aclk`, in, 1: single clock.
- `axi_resetn`, in, 1: reset, asynchronous and active-low.
- `s_axis_tdata`, in, C_AXIS_DATA_WIDTH: input data.
- `s_axis_tstrb`, in, C_AXIS_DATA_WIDTH/8: byte strobes, contiguous from the LSB.
- `s_axis_tuser`, in, C_AXIS_TUSER_WIDTH: sampled on the first beat only.
- `s_axis_tvalid`, in, 1.
- `s_axis_tready`, out, 1.
- `s_axis_tlast`, in, 1.
- `m_axis_tdata`, out, C_AXIS_DATA_WIDTH.
- `m_axis_tstrb`, out, C_AXIS_DATA_WIDTH/8.
- `m_axis_tuser`, out, C_AXIS_TUSER_WIDTH.
- `m_axis_tvalid`, out, 1.
- `m_axis_tready`, in, 1.
- `m_axis_tlast`, out, 1.
- `drop_count`, out, 32: number of packets dropped since reset; wraps at 2^32.

## Operation
Storage:
- Data RAM holds {tdata, tstrb, tlast}, one word per beat. Read is asynchronous (distributed RAM).
- Pointers are C_DEPTH_LOG2+1 bits wide:
  - `wr_ptr` is the speculative write pointer.
  - `wr_commit` marks the end of the last complete packet.
  - `rd_ptr` is the read pointer.
- Used words = `wr_ptr - rd_ptr`, modulo 2^(C_DEPTH_LOG2+1).
- Meta FIFO entry = first-beat `tuser`, with bits [15:0] replaced by the packet byte length.

Write side FSM:
- States: `W_FIRST`, `W_BODY`, `W_DROP`.
- `s_axis_tready` = ~meta_full in every state. Meta full is the only source of back-pressure.
- Beat accept = `s_axis_tvalid & s_axis_tready`.
- Per accepted beat:
  - `len_acc` += popcount(tstrb), 16-bit, reset to 0 at `W_FIRST`.
  - In `W_FIRST`, latch `s_axis_tuser`.
- Overflow: an accepted beat in `W_FIRST`/`W_BODY` while used == 2^C_DEPTH_LOG2.
  - The beat is discarded.
  - `wr_ptr` <= `wr_commit`.
  - `drop_count` +1.
  - Go to `W_DROP`, or stay in `W_FIRST` if that beat had tlast.
- `W_DROP`: accepted beats are discarded; on tlast go to `W_FIRST`.
- Non-overflow beat: write RAM[wr_ptr], `wr_ptr` +1.
  - Without tlast: `W_FIRST` -> `W_BODY`.
  - With tlast: `wr_commit` <= `wr_ptr`+1, push the meta entry (stored `tuser`, or live `s_axis_tuser` for a single-beat packet; length = `len_acc` + popcount), go to `W_FIRST`.
- Packets longer than 2^C_DEPTH_LOG2 beats are always dropped.
- The full check uses registered `rd_ptr`. Space freed by a read in the same cycle is not seen until the next cycle.

Read side FSM:
- States: `R_IDLE`, `R_SEND`.
- `R_IDLE`:
  - `m_axis_tvalid` = ~meta_empty.
  - Data comes from RAM[rd_ptr].
  - `m_axis_tuser` = meta head.
  - On handshake, pop meta and go to `R_SEND`, or stay in `R_IDLE` if tlast.
- `R_SEND`:
  - `m_axis_tvalid` = 1.
  - `m_axis_tuser` = 0.
  - On handshake with tlast, go to `R_IDLE`.
- Every handshake increments `rd_ptr`.
- The read side never passes `wr_commit`. This is guaranteed because meta exists only for committed packets.

## Timing
- Reset, asynchronous: all pointers 0, both FSMs idle (`W_FIRST`, `R_IDLE`), meta FIFO empty, `drop_count` 0.
- Reset output values: `m_axis_tvalid` 0, `m_axis_tlast` 0, `m_axis_tuser` 0, `s_axis_tready` 1.
- Latency: the tlast beat is accepted at edge N; `m_axis_tvalid` is high in the cycle after edge N. The first output beat is combinational from registered state.
- With continuous `m_axis_tready`, throughput is 1 beat/cycle on each side independently.
- Simultaneous meta push and pop: the count is unchanged. When meta is full, a pop does not raise `s_axis_tready` in the same cycle.
- AXI rules:
  - `m_axis_tdata`, `m_axis_tstrb`, `m_axis_tuser` and `m_axis_tlast` are stable while `m_axis_tvalid` is high and `m_axis_tready` is low.
  - `m_axis_tvalid` never drops without a handshake.
- Reset mid-packet: a partially written packet is lost and is not counted as a drop. A partially read packet is truncated with no tlast.

## Test plan
- Single packet: 3 beats with tstrb FF, FF, 0F and `s_axis_tuser` = 0xABCD_0000 -> one output packet of 3 beats, first-beat `m_axis_tuser[31:0]` = 0xABCD_0014 (length 20), later beats `tuser` 0, `m_axis_tvalid` rises 1 cycle after input tlast.
- Back-pressure: 4 packets of 2 beats while `m_axis_tready` toggles 1010… -> data identical and in order, outputs held stable during stalls, `drop_count` 0.
- Overflow: C_DEPTH_LOG2=3, a 10-beat packet followed by a 2-beat packet -> first packet absent, `drop_count` = 1, second packet delivered with length 16.
- Meta full: C_META_DEPTH_LOG2=2, 5 single-beat packets with `m_axis_tready` = 0 -> `s_axis_tready` low after 4 packets; after 1 output pop, it is high again the following cycle and the 5th packet is accepted.
- Single-beat packet with tstrb 01 -> length 1, `m_axis_tlast` = 1 on the first beat, meta pop and `R_IDLE` retained.
- Reset asserted mid-packet (2 of 4 beats in, 1 packet queued) -> `m_axis_tvalid` 0 immediately, after release the buffer is empty, the next packet passes intact.
